// File: rtl/arbiter_pkg.sv
// Shared definitions for the N-way arbiter family: FSM state encoding and
// a width helper that other N-way blocks reuse for index signals.
package arbiter_pkg;

  // Arbiter FSM states: no holder / a holder owns the resource.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  // Bits needed to index n items; never less than 1 so a 1-bit index
  // still exists for degenerate sizes.
  function automatic int width_for(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rotating_first_one.sv
// Cyclic first-set-bit finder: searches i_req starting at i_start, walking
// upward and wrapping to 0. Purely combinational. Built as a masked /
// unmasked pair: the lowest set bit at or above i_start wins, otherwise the
// lowest set bit overall.
module rotating_first_one
  import arbiter_pkg::*;
#(
  parameter int N = 4,
  parameter int W = width_for(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_start,
  output logic         o_found,
  output logic [W-1:0] o_index
);

  logic         w_hi_found;
  logic         w_lo_found;
  logic [W-1:0] w_hi_idx;
  logic [W-1:0] w_lo_idx;

  // Scan downward so the lowest qualifying index is the last one written.
  always_comb begin
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        w_lo_found = 1'b1;
        w_lo_idx   = W'(i);
        if (i >= int'(i_start)) begin
          w_hi_found = 1'b1;
          w_hi_idx   = W'(i);
        end
      end
    end
  end

  assign o_found = w_lo_found;
  assign o_index = w_hi_found ? w_hi_idx : w_lo_idx;

endmodule

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter with grant locking. The holder keeps the resource
// until it drops its request; the next arbitration starts one past the last
// winner. All outputs come straight from registers.
// Optional feature macro: ARBITER_TIMEOUT_EN -- when defined, a holder is
// forced to re-arbitrate after MAX_HOLD consecutive grant cycles.
//
// Handshake: request[i] is a level held by requester i for as long as it
// wants or uses the resource; grant[i]/user/valid answer one cycle later and
// stay put while request[user] stays high. Dropping request[user] releases
// the resource at the next edge, and a waiting requester is granted at that
// same edge with no idle cycle.
module round_robin_arbiter
  import arbiter_pkg::*;
#(
  parameter int NUM_USERS  = 4,
  parameter int USER_WIDTH = width_for(NUM_USERS),
  parameter int MAX_HOLD   = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_USERS-1:0]  request,
  output logic                  valid,
  output logic [USER_WIDTH-1:0] user,
  output logic [NUM_USERS-1:0]  grant
);

  // Elaboration-time parameter sanity.
  if (NUM_USERS < 2 || MAX_HOLD < 1) begin : g_bad_param
    $error("round_robin_arbiter: NUM_USERS must be >= 2 and MAX_HOLD >= 1");
  end

  arb_state_t            r_state;
  arb_state_t            w_state_next;
  logic [USER_WIDTH-1:0] r_ptr;
  logic [USER_WIDTH-1:0] w_ptr_next;
  logic [USER_WIDTH-1:0] r_user;
  logic [USER_WIDTH-1:0] w_user_next;
  logic [NUM_USERS-1:0]  r_grant;
  logic [NUM_USERS-1:0]  w_grant_next;

  logic                  w_holder_req;
  logic                  w_force;
  logic                  w_arb;
  logic [NUM_USERS-1:0]  w_search_req;
  logic                  w_found;
  logic [USER_WIDTH-1:0] w_win;
  logic [USER_WIDTH-1:0] w_base;
  logic [USER_WIDTH-1:0] w_ptr_after;

`ifdef ARBITER_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0] r_hold;
  logic [HOLD_W-1:0] w_hold_next;

  // Holder has used its full budget but still wants more.
  assign w_force = (r_state == ST_BUSY) && w_holder_req &&
                   (r_hold == HOLD_W'(MAX_HOLD));
`else
  assign w_force = 1'b0;
`endif

  assign w_holder_req = request[r_user];
  assign w_arb        = (r_state == ST_IDLE) || !w_holder_req || w_force;
  // On a forced arbitration the holder must not win against itself.
  assign w_search_req = w_force ? (request & ~r_grant) : request;

  rotating_first_one #(
    .N (NUM_USERS),
    .W (USER_WIDTH)
  ) u_finder (
    .i_req   (w_search_req),
    .i_start (r_ptr),
    .o_found (w_found),
    .o_index (w_win)
  );

  // Pointer moves one past whoever gets the grant, wrapping at NUM_USERS-1
  // rather than at the power-of-two boundary.
  assign w_base      = w_found ? w_win : r_user;
  assign w_ptr_after = (w_base == USER_WIDTH'(NUM_USERS - 1)) ?
                       '0 : w_base + USER_WIDTH'(1);

  // Next-state and next-output logic for the IDLE/BUSY machine.
  always_comb begin
    w_state_next = r_state;
    w_user_next  = r_user;
    w_grant_next = r_grant;
    w_ptr_next   = r_ptr;
`ifdef ARBITER_TIMEOUT_EN
    w_hold_next  = r_hold;
`endif
    if (w_arb) begin
      if (w_found) begin
        w_state_next = ST_BUSY;
        w_user_next  = w_win;
        w_grant_next = NUM_USERS'(1) << w_win;
        w_ptr_next   = w_ptr_after;
`ifdef ARBITER_TIMEOUT_EN
        w_hold_next  = HOLD_W'(1);
`endif
      end else if (w_force) begin
        // Nobody else is waiting: the holder is re-granted in place.
        w_ptr_next   = w_ptr_after;
`ifdef ARBITER_TIMEOUT_EN
        w_hold_next  = HOLD_W'(1);
`endif
      end else begin
        w_state_next = ST_IDLE;
        w_user_next  = '0;
        w_grant_next = '0;
`ifdef ARBITER_TIMEOUT_EN
        w_hold_next  = '0;
`endif
      end
    end else begin
`ifdef ARBITER_TIMEOUT_EN
      w_hold_next = r_hold + HOLD_W'(1);
`endif
    end
  end

  // State, pointer and output registers; reset wins over everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_user  <= '0;
      r_grant <= '0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
      r_user  <= w_user_next;
      r_grant <= w_grant_next;
    end
  end

`ifdef ARBITER_TIMEOUT_EN
  // Consecutive-grant-cycle counter for the current holder.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_hold <= '0;
    end else begin
      r_hold <= w_hold_next;
    end
  end
`endif

  assign valid = (r_state == ST_BUSY);
  assign user  = r_user;
  assign grant = r_grant;

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Directed bench for round_robin_arbiter: a 4-user instance (MAX_HOLD=4)
// and a 5-user instance for non-power-of-two wrap. Honors ARBITER_TIMEOUT_EN
// when the macro is defined for the build.
module tb_round_robin_arbiter;

  // ---------------- clock / reset ----------------
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] request = 4'b0000;
  logic       valid;
  logic [1:0] user;
  logic [3:0] grant;

  logic [4:0] request5 = 5'b00000;
  logic       valid5;
  logic [2:0] user5;
  logic [4:0] grant5;

  always #5 clock = ~clock;

  round_robin_arbiter #(
    .NUM_USERS (4),
    .MAX_HOLD  (4)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .request (request),
    .valid   (valid),
    .user    (user),
    .grant   (grant)
  );

  round_robin_arbiter #(
    .NUM_USERS (5)
  ) dut5 (
    .clock   (clock),
    .reset   (reset),
    .request (request5),
    .valid   (valid5),
    .user    (user5),
    .grant   (grant5)
  );

  // ---------------- scoreboard ----------------
  int         errors = 0;
  int         checks = 0;
  logic [1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic exp_valid,
                         input logic [1:0] exp_user, input logic [3:0] exp_grant);
    check({tag, ".valid"}, 32'(valid), 32'(exp_valid));
    check({tag, ".user"},  32'(user),  32'(exp_user));
    check({tag, ".grant"}, 32'(grant), 32'(exp_grant));
  endtask

  task automatic chk_out5(input string tag, input logic exp_valid,
                          input logic [2:0] exp_user, input logic [4:0] exp_grant);
    check({tag, ".valid"}, 32'(valid5), 32'(exp_valid));
    check({tag, ".user"},  32'(user5),  32'(exp_user));
    check({tag, ".grant"}, 32'(grant5), 32'(exp_grant));
  endtask

  // ---------------- driver tasks ----------------
  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    request = 4'b0000;
    request5 = 5'b00000;
    step();
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0] cur;
    logic [1:0] nxt;
    logic [3:0] oh;

    // Reset held 3 cycles with all requests high.
    request = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("reset_hold", 1'b0, 2'd0, 4'b0000);
    end
    reset = 1'b0;
    step();
    chk_out("first_grant", 1'b1, 2'd0, 4'b0001);

    // Single requester 2: granted next cycle, stable for 10 cycles.
    do_reset();
    chk_out("reset_again", 1'b0, 2'd0, 4'b0000);
    request = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_out("hold_u2", 1'b1, 2'd2, 4'b0100);
    end
    request = 4'b0000;
    step();
    chk_out("release_idle", 1'b0, 2'd0, 4'b0000);

    // ptr is 3 now: search 3,0,1 -> user 0 wins, not 1.
    request = 4'b0011;
    step();
    chk_out("wrap_u0", 1'b1, 2'd0, 4'b0001);

    // Rotation with all requesting; each holder drops for 1 cycle after 3.
    do_reset();
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    request = 4'b1111;
    step();
    for (int k = 0; k < 5; k++) begin
      cur = exp_q.pop_front();
      oh  = 4'b0001 << cur;
      for (int c = 0; c < 3; c++) begin
        chk_out("rotate", 1'b1, cur, oh);
        if (c < 2) step();
      end
      request = 4'b1111 & ~oh;
      step();
      nxt = cur + 2'd1;
      chk_out("handover", 1'b1, nxt, 4'b0001 << nxt);
      request = 4'b1111;
    end
    check("rotate_queue_empty", 32'(exp_q.size()), 32'd0);

    // Holder 1 drops at the same edge request[3] rises.
    do_reset();
    request = 4'b0010;
    step();
    chk_out("u1_grant", 1'b1, 2'd1, 4'b0010);
    request = 4'b1000;
    step();
    chk_out("direct_u3", 1'b1, 2'd3, 4'b1000);
    reset = 1'b1;
    step();
    chk_out("mid_reset", 1'b0, 2'd0, 4'b0000);
    reset = 1'b0;

    // Hold limit with two contenders.
    request = 4'b0011;
    for (int i = 0; i < 12; i++) begin
      step();
`ifdef ARBITER_TIMEOUT_EN
      cur = ((i / 4) % 2 == 0) ? 2'd0 : 2'd1;
`else
      cur = 2'd0;
`endif
      chk_out("timeout_pair", 1'b1, cur, 4'b0001 << cur);
    end

    // Lone requester keeps the grant either way.
    do_reset();
    request = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_out("timeout_lone", 1'b1, 2'd0, 4'b0001);
    end

    // Five users: reach ptr=4, then only request 1 -> user 1.
    do_reset();
    request5 = 5'b01000;
    step();
    chk_out5("n5_u3", 1'b1, 3'd3, 5'b01000);
    request5 = 5'b00010;
    step();
    chk_out5("n5_wrap_u1", 1'b1, 3'd1, 5'b00010);
    // ptr=2: search 2,3,4 -> user 4, ptr wraps to 0.
    request5 = 5'b10001;
    step();
    chk_out5("n5_u4", 1'b1, 3'd4, 5'b10000);
    request5 = 5'b00001;
    step();
    chk_out5("n5_u0", 1'b1, 3'd0, 5'b00001);
    request5 = 5'b00000;
    step();
    chk_out5("n5_idle", 1'b0, 3'd0, 5'b00000);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/round_robin_arbiter.md
# round_robin_arbiter

Parametrised N-way arbiter granting one shared resource to one of `NUM_USERS` requesters. Rotating priority gives fairness, and the grant is locked to its holder until that holder drops its request. All outputs are registered. It replaces fixed-priority encoding wherever starvation of high-index requesters is unacceptable, e.g. shared SRAM or UART ports in lab designs.

## Interface
- `NUM_USERS`, default 4: number of requesters, must be ≥ 2.
- `USER_WIDTH`, default `$clog2(NUM_USERS)`: width of `user`; derived, never overridden.
- `MAX_HOLD`, default 16: maximum consecutive grant cycles; used only with `ARBITER_TIMEOUT_EN`; must be ≥ 1.
- One clock; reset is synchronous and active-high.
- `clock`  in  1: rising-edge clock.
- `reset`  in  1: synchronous, active-high reset.
- `request`  in  NUM_USERS: request bit per requester; level-held while wanting or using the resource.
- `valid`  out  1: a grant is active.
- `user`  out  USER_WIDTH: index of the current holder; 0 when `valid`=0.
- `grant`  out  NUM_USERS: one-hot holder; all-zero when `valid`=0.

## Operation
- State machine with two states:
  - IDLE: no holder.
  - BUSY: holder in `user`.
- Rotating pointer `ptr` (USER_WIDTH bits) is the highest-priority index for the next arbitration.
- Arbitration event: the state is IDLE, or the state is BUSY and `request[user]`=0.
- Winner: the first set bit of `request` found by searching cyclically `ptr`, `ptr+1`, …, `NUM_USERS-1`, 0, …, `ptr-1`.
- On arbitration with a winner w:
  - state←BUSY, `user`←w, `grant`←onehot(w), `valid`←1.
  - `ptr`←w+1, wrapping `NUM_USERS-1`→0.
- On arbitration with no request: state←IDLE, `valid`←0, `user`←0, `grant`←0; `ptr` unchanged.
- BUSY with `request[user]`=1: outputs unchanged (lock). Other requesters' bits are ignored.
- Holder release with another requester present: handover happens directly, with no idle cycle and `valid` staying 1.
- Non-power-of-two `NUM_USERS`: the pointer wraps at `NUM_USERS-1`, never at `2^USER_WIDTH-1`. `user` never holds an index ≥ `NUM_USERS`.
- Reset, including mid-grant: state IDLE, `valid`=0, `user`=0, `grant`=0, `ptr`=0, hold counter 0.

## Timing
- Request-to-grant latency: 1 cycle. A request sampled at edge k makes `valid`/`user`/`grant` valid after edge k.
- Release-to-next-grant latency: 1 cycle. The holder's `request` low at edge k updates the outputs after edge k.
- No combinational path from `request` to any output.
- `valid`, `user` and `grant` are always mutually consistent in every cycle.
- Reset has priority over all other events at the same edge.

## Configuration
- Macro: `ARBITER_TIMEOUT_EN`.
- Defined:
  - Hold counter `hold_cnt`, width `$clog2(MAX_HOLD+1)`, set to 1 on every new grant and incremented each BUSY cycle.
  - When `hold_cnt`==`MAX_HOLD` and the holder still requests, a forced arbitration runs with the holder's bit masked.
  - If another requester wins, it takes the grant next cycle.
  - If no other requester exists, the holder is re-granted, `hold_cnt`←1, and `ptr` is updated as for a normal grant.
- Undefined: no counter is built, `MAX_HOLD` is ignored, and a holder keeps the grant indefinitely.

## Structure
- The shared package `arbiter_pkg` holds:
  - state encodings `ST_IDLE`=0 and `ST_BUSY`=1;
  - a `clog2`-based width helper, reused by other N-way blocks.
- Sub-module `rotating_first_one`: combinational cyclic first-set-bit finder.
  - Inputs: request vector and start index.
  - Outputs: found flag and index.
  - Implemented as double-width concatenation with masking, or as a masked/unmasked pair.
- The top level owns the FSM, the pointer, the output registers and the optional hold counter.

## Test plan
- Reset held 3 cycles with `request`=4'b1111 → `valid`=0, `user`=0, `grant`=0 throughout; 1 cycle after release, `user`=0 and `grant`=4'b0001.
- From idle after reset, `request`=4'b0100 held 10 cycles → `user`=2, `grant`=4'b0100 from the next cycle, stable 10 cycles; drop request → `valid`=0 next cycle.
- `request`=4'b1111, with each holder clearing its own bit for 1 cycle after 3 granted cycles → grant order 0,1,2,3,0; `valid` stays 1 with no gap.
- Wrap-around: after user 2 releases (`ptr`=3), `request`=4'b0011 → `user`=0, not 1; with `NUM_USERS`=5 and `ptr`=4, `request`=5'b00010 → `user`=1.
- Holder 1 drops at the edge where `request[3]` rises → next cycle `user`=3 and `valid`=1; `reset` asserted mid-grant → all outputs 0 next cycle.
- `ARBITER_TIMEOUT_EN`, `MAX_HOLD`=4, `request`=4'b0011 constant → user 0 for 4 cycles, user 1 for 4, repeating; with only 4'b0001, user 0 continuous; without the macro, user 0 forever.
